// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp sequencer: register map, FSM states
// and the position clamp helper.
package servo_pkg;

    localparam logic [1:0] REG_TARGET = 2'd0;
    localparam logic [1:0] REG_STEP   = 2'd1;
    localparam logic [1:0] REG_STATUS = 2'd2;
    localparam logic [1:0] REG_SPARE  = 2'd3;

    localparam int DEFAULT_MAX_POS = 10;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        ISSUE
    } ramp_state_t;

    function automatic logic [7:0] clampTarget(input logic [7:0] value,
                                               input logic [7:0] maxPos);
        return (value > maxPos) ? maxPos : value;
    endfunction

endpackage

// File: rtl/frame_tick.sv
// Free-running frame counter producing a one-cycle tick on the last cycle of
// every FRAME_CYCLES-long servo frame.
module frame_tick #(
    parameter int FRAME_CYCLES = 720000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/servo_ramp.sv
// Memory-mapped motion sequencer: walks the servo position one step per
// programmed number of frames toward a target, pushing each position out as
// a bus-master write to the servo selector register.
module servo_ramp
    import servo_pkg::*;
#(
    parameter int          FRAME_CYCLES = 720000,
    parameter int          MAX_POS      = DEFAULT_MAX_POS,
    parameter logic [31:0] SERVO_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] m_address_out,
    output logic        m_sel_out,
    output logic [3:0]  m_write_mask_out,
    output logic [31:0] m_write_value_out,
    input  logic        m_ready_in,
    output logic        busy_out,
    output logic [7:0]  position_out
);

    localparam logic [7:0] MAX_POS_B = 8'(MAX_POS);

    ramp_state_t state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [7:0]  stepFrames_q, stepFrames_d;
    logic [7:0]  current_q, current_d;
    logic [7:0]  stepCount_q, stepCount_d;
    logic        stepDue_q, stepDue_d;
    logic        mSel_q, mSel_d;

    logic        tick;
    logic        wrEn;
    logic        consume;
    logic        stepExpire;
    logic [7:0]  stepFloor;
    logic        unusedBits;

    assign unusedBits = ^{address_in[31:4], address_in[1:0],
                          write_mask_in[3:1], write_value_in[31:8]};

    frame_tick #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) uFrameTick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign wrEn = sel_in && write_mask_in[0];

    always_comb begin
        target_d     = target_q;
        stepFrames_d = stepFrames_q;
        if (wrEn) begin
            case (address_in[3:2])
                REG_TARGET: target_d     = clampTarget(write_value_in[7:0], MAX_POS_B);
                REG_STEP:   stepFrames_d = write_value_in[7:0];
                default:    ;
            endcase
        end
    end

    // A programmed step count of zero behaves like one; a tick while a step
    // is already pending leaves just that single step pending.
    always_comb begin
        stepFloor   = (stepFrames_q == 8'd0) ? 8'd1 : stepFrames_q;
        stepCount_d = stepCount_q;
        stepExpire  = 1'b0;
        if (tick) begin
            if ((stepCount_q + 8'd1) >= stepFloor) begin
                stepCount_d = 8'd0;
                stepExpire  = 1'b1;
            end else begin
                stepCount_d = stepCount_q + 8'd1;
            end
        end
        stepDue_d = stepDue_q;
        if (consume) begin
            stepDue_d = 1'b0;
        end
        if (stepExpire) begin
            stepDue_d = 1'b1;
        end
    end

    // The master request is registered so it is low in the reset cycle;
    // SYNC raises it one cycle after reset releases.
    always_comb begin
        state_d   = state_q;
        mSel_d    = mSel_q;
        current_d = current_q;
        consume   = 1'b0;
        case (state_q)
            SYNC: begin
                if (!mSel_q) begin
                    mSel_d = 1'b1;
                end else if (m_ready_in) begin
                    mSel_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (stepDue_q) begin
                    consume = 1'b1;
                    if (current_q < target_q) begin
                        current_d = current_q + 8'd1;
                        mSel_d    = 1'b1;
                        state_d   = ISSUE;
                    end else if (current_q > target_q) begin
                        current_d = current_q - 8'd1;
                        mSel_d    = 1'b1;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (m_ready_in) begin
                    mSel_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                mSel_d  = 1'b0;
                state_d = SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SYNC;
            mSel_q       <= 1'b0;
            current_q    <= 8'd0;
            target_q     <= 8'd0;
            stepFrames_q <= 8'd1;
            stepCount_q  <= 8'd0;
            stepDue_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            mSel_q       <= mSel_d;
            current_q    <= current_d;
            target_q     <= target_d;
            stepFrames_q <= stepFrames_d;
            stepCount_q  <= stepCount_d;
            stepDue_q    <= stepDue_d;
        end
    end

    assign busy_out          = (current_q != target_q) || (state_q != IDLE);
    assign position_out      = current_q;
    assign ready_out         = sel_in;
    assign m_address_out     = SERVO_ADDR;
    assign m_sel_out         = mSel_q;
    assign m_write_mask_out  = mSel_q ? 4'b0001 : 4'b0000;
    assign m_write_value_out = mSel_q ? {24'b0, current_q} : 32'b0;

    always_comb begin
        read_value_out = 32'b0;
        if (sel_in && read_in) begin
            case (address_in[3:2])
                REG_TARGET: read_value_out = {24'b0, target_q};
                REG_STEP:   read_value_out = {24'b0, stepFrames_q};
                REG_STATUS: read_value_out = {23'b0, busy_out, current_q};
                default:    read_value_out = 32'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp: directed ramp scenarios plus random
// register/bus traffic, all compared every cycle against a behavioural model.
module tb_servo_ramp;

    localparam int          FRAME = 10;
    localparam int          MAXP  = 10;
    localparam logic [31:0] SADDR = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] address_in = '0;
    logic        sel_in = 1'b0;
    logic        read_in = 1'b0;
    logic [3:0]  write_mask_in = '0;
    logic [31:0] write_value_in = '0;
    logic        m_ready_in = 1'b1;
    logic [31:0] read_value_out;
    logic        ready_out;
    logic [31:0] m_address_out;
    logic        m_sel_out;
    logic [3:0]  m_write_mask_out;
    logic [31:0] m_write_value_out;
    logic        busy_out;
    logic [7:0]  position_out;

    servo_ramp #(
        .FRAME_CYCLES(FRAME),
        .MAX_POS     (MAXP),
        .SERVO_ADDR  (SADDR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .address_in       (address_in),
        .sel_in           (sel_in),
        .read_in          (read_in),
        .read_value_out   (read_value_out),
        .write_mask_in    (write_mask_in),
        .write_value_in   (write_value_in),
        .ready_out        (ready_out),
        .m_address_out    (m_address_out),
        .m_sel_out        (m_sel_out),
        .m_write_mask_out (m_write_mask_out),
        .m_write_value_out(m_write_value_out),
        .m_ready_in       (m_ready_in),
        .busy_out         (busy_out),
        .position_out     (position_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int logVal[$];
    int logCyc[$];

    // Model: frame phase, frames counted toward the next step, pending step,
    // position, target, step setting, write in flight, and whether the
    // post-reset sync write has finished.
    int mPh = 0, mSc = 0, mPos = 0, mTgt = 0, mSf = 1;
    bit mDue = 0, mAct = 0, mSynced = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic modelStep();
        bit tickNow, consume, expire;
        int floorSf, n;
        if (reset) begin
            mPh = 0; mSc = 0; mDue = 0; mPos = 0; mTgt = 0; mSf = 1;
            mAct = 0; mSynced = 0;
            return;
        end
        tickNow = (mPh == FRAME - 1);
        mPh     = (mPh + 1) % FRAME;
        consume = mSynced && !mAct && mDue;
        expire  = 0;
        if (tickNow) begin
            floorSf = (mSf == 0) ? 1 : mSf;
            n = mSc + 1;
            if (n >= floorSf) begin
                mSc = 0;
                expire = 1;
            end else begin
                mSc = n;
            end
        end
        if (mAct && m_ready_in) begin
            mAct = 0;
            mSynced = 1;
        end else if (!mSynced && !mAct) begin
            mAct = 1;
        end else if (consume && mPos != mTgt) begin
            mPos = (mTgt > mPos) ? mPos + 1 : mPos - 1;
            mAct = 1;
        end
        if (consume) mDue = 0;
        if (expire) mDue = 1;
        if (sel_in && write_mask_in[0]) begin
            case (address_in[3:2])
                2'd0: mTgt = (int'(write_value_in[7:0]) > MAXP) ? MAXP : int'(write_value_in[7:0]);
                2'd1: mSf = int'(write_value_in[7:0]);
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] expectedRead();
        bit busy;
        busy = (mPos != mTgt) || !(mSynced && !mAct);
        if (!(sel_in && read_in)) return 32'h0;
        case (address_in[3:2])
            2'd0: return 32'(mTgt);
            2'd1: return 32'(mSf);
            2'd2: return (32'(busy) << 8) | 32'(mPos);
            default: return 32'h0;
        endcase
    endfunction

    // Log completed master writes (pre-edge values), advance the model, then
    // compare every output shortly after the edge.
    always @(posedge clk) begin
        cyc++;
        if (!reset && m_sel_out && m_ready_in) begin
            logVal.push_back(int'(m_write_value_out));
            logCyc.push_back(cyc);
        end
        modelStep();
        #1;
        checkOutput("m_sel", 32'(m_sel_out), 32'(mAct));
        checkOutput("m_addr", m_address_out, SADDR);
        checkOutput("m_mask", 32'(m_write_mask_out), mAct ? 32'h1 : 32'h0);
        checkOutput("m_data", m_write_value_out, mAct ? 32'(mPos) : 32'h0);
        checkOutput("position", 32'(position_out), 32'(mPos));
        checkOutput("busy", 32'(busy_out),
                    32'((mPos != mTgt) || !(mSynced && !mAct)));
        checkOutput("ready", 32'(ready_out), 32'(sel_in));
        checkOutput("read_data", read_value_out, expectedRead());
    end

    function automatic logic [31:0] logAt(input int i);
        if (i >= 0 && i < logVal.size()) return 32'(logVal[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gapAt(input int i);
        if (i >= 1 && i < logCyc.size()) return 32'(logCyc[i] - logCyc[i-1]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic applyStimulus(input logic [1:0] regIdx, input logic [31:0] val);
        @(negedge clk);
        address_in     = {28'h0, regIdx, 2'b00};
        sel_in         = 1'b1;
        write_mask_in  = 4'b0001;
        write_value_in = val;
        @(negedge clk);
        sel_in         = 1'b0;
        write_mask_in  = 4'b0000;
        write_value_in = '0;
        address_in     = '0;
    endtask

    task automatic readReg(input logic [1:0] regIdx, output logic [31:0] val);
        @(negedge clk);
        address_in = {28'h0, regIdx, 2'b00};
        sel_in     = 1'b1;
        read_in    = 1'b1;
        #1 val = read_value_out;
        #1;
        sel_in     = 1'b0;
        read_in    = 1'b0;
        address_in = '0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitPos(input int v, input int budget);
        int k = 0;
        while (int'(position_out) != v && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("wait_position", 32'(position_out), 32'(v));
    endtask

    task automatic waitSel(input int budget);
        int k = 0;
        while (m_sel_out !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput("wait_m_sel", 32'(m_sel_out), 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        int base;
        int r;
        logic [1:0] ri;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Sync write of 0 after reset release.
        waitCycles(5);
        checkOutput("sync_count", 32'(logVal.size()), 32'd1);
        checkOutput("sync_value", logAt(0), 32'd0);
        readReg(2'd2, rd);
        checkOutput("status_after_sync", rd, 32'h000);

        // Ramp to 3 at one step per frame.
        base = logVal.size();
        applyStimulus(2'd0, 32'd3);
        waitCycles(45);
        checkOutput("ramp3_count", 32'(logVal.size() - base), 32'd3);
        checkOutput("ramp3_w0", logAt(base), 32'd1);
        checkOutput("ramp3_w1", logAt(base + 1), 32'd2);
        checkOutput("ramp3_w2", logAt(base + 2), 32'd3);
        checkOutput("ramp3_gap1", gapAt(base + 1), 32'd10);
        checkOutput("ramp3_gap2", gapAt(base + 2), 32'd10);
        readReg(2'd2, rd);
        checkOutput("ramp3_status", rd, 32'h003);

        // Out-of-range target clamps to the maximum position.
        applyStimulus(2'd0, 32'd200);
        readReg(2'd0, rd);
        checkOutput("clamp_readback", rd, 32'd10);
        waitPos(10, 100);
        waitCycles(15);
        checkOutput("clamp_final_pos", 32'(position_out), 32'd10);
        checkOutput("clamp_final_busy", 32'(busy_out), 32'd0);

        // Step setting 0 behaves like 1.
        applyStimulus(2'd1, 32'd0);
        readReg(2'd1, rd);
        checkOutput("step0_readback", rd, 32'd0);
        base = logVal.size();
        applyStimulus(2'd0, 32'd7);
        waitCycles(45);
        checkOutput("step0_w0", logAt(base), 32'd9);
        checkOutput("step0_w2", logAt(base + 2), 32'd7);
        checkOutput("step0_gap", gapAt(base + 1), 32'd10);

        // Three frames per step.
        applyStimulus(2'd1, 32'd3);
        base = logVal.size();
        applyStimulus(2'd0, 32'd4);
        waitCycles(110);
        checkOutput("step3_w0", logAt(base), 32'd6);
        checkOutput("step3_w2", logAt(base + 2), 32'd4);
        checkOutput("step3_gap1", gapAt(base + 1), 32'd30);
        checkOutput("step3_gap2", gapAt(base + 2), 32'd30);

        // Reversal mid-ramp: heads straight back without overshoot.
        applyStimulus(2'd1, 32'd1);
        applyStimulus(2'd0, 32'd8);
        waitPos(5, 60);
        applyStimulus(2'd0, 32'd2);
        base = logVal.size();
        checkOutput("retarget_last_up", logAt(base - 1), 32'd5);
        waitCycles(45);
        checkOutput("retarget_w0", logAt(base), 32'd4);
        checkOutput("retarget_w1", logAt(base + 1), 32'd3);
        checkOutput("retarget_w2", logAt(base + 2), 32'd2);

        // Servo stalls the write for 25 cycles.
        m_ready_in = 1'b0;
        applyStimulus(2'd0, 32'd10);
        waitSel(30);
        repeat (25) begin
            @(negedge clk);
            checkOutput("stall_sel", 32'(m_sel_out), 32'h1);
            checkOutput("stall_data", m_write_value_out, 32'd3);
        end
        base = logVal.size();
        m_ready_in = 1'b1;
        waitCycles(4);
        checkOutput("stall_w0", logAt(base), 32'd3);
        checkOutput("stall_w1", logAt(base + 1), 32'd4);
        checkOutput("stall_gap", gapAt(base + 1), 32'd2);

        // Reset while the write of position 6 is in flight.
        waitPos(6, 40);
        checkOutput("pre_reset_sel", 32'(m_sel_out), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("reset_sel", 32'(m_sel_out), 32'h0);
        checkOutput("reset_data", m_write_value_out, 32'h0);
        checkOutput("reset_pos", 32'(position_out), 32'h0);
        reset = 1'b0;
        base = logVal.size();
        waitCycles(5);
        checkOutput("reset_sync_value", logAt(base), 32'd0);
        readReg(2'd0, rd);
        checkOutput("reset_target", rd, 32'd0);

        // Random register traffic and servo back-pressure.
        repeat (500) begin
            @(negedge clk);
            r  = int'($urandom_range(0, 99));
            ri = 2'($urandom_range(0, 3));
            m_ready_in = ($urandom_range(0, 9) != 0);
            sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0; write_value_in = '0;
            address_in = ($urandom & 32'hFFFF_FFF3) | {28'h0, ri, 2'b00};
            if (r < 10) begin
                sel_in = 1'b1;
                write_mask_in = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 4) != 0)};
                if (ri == 2'd1) write_value_in = $urandom_range(0, 3);
                else if ($urandom_range(0, 3) == 0) write_value_in = $urandom;
                else write_value_in = $urandom_range(0, 12);
            end else if (r < 25) begin
                sel_in = 1'b1;
                read_in = 1'b1;
            end
        end
        @(negedge clk);
        sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0; address_in = '0;
        m_ready_in = 1'b1;
        waitCycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
